m_proc_mc: RTL

//  Parametrised multi-cycle RV32I-subset core: successor to the single-cycle x1-only adder datapath.

---
 rtl/m_proc_mc_if.sv | 11 +
 rtl/m_proc_mc.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/m_proc_mc_if.sv
// m_proc_mc_if: req/ack memory port shared by the instruction and data sides of m_proc_mc.
interface m_proc_mc_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/m_proc_mc.sv
// m_proc_mc: multi-cycle RV32I-subset core (ADD/SUB/ADDI/LW/SW/BEQ/BNE/JAL/ECALL)
// with req/ack instruction and data ports, a retire counter and halt/trap reporting.
module m_proc_mc #(
    parameter int          XLEN     = 32,
    parameter int          NREGS    = 32,
    parameter logic [31:0] PC_RESET = 32'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    m_proc_mc_if.master      imem,
    m_proc_mc_if.master      dmem,
    output logic             halt,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);
    if (XLEN != 32 || (NREGS != 32 && NREGS != 16)) begin : g_bad_cfg
        $error("m_proc_mc: XLEN must be 32 and NREGS must be 16 or 32");
    end

    typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, HALT} state_t;
    localparam logic [5:0] NR = 6'(NREGS);

    state_t          state;
    logic [31:0]     pc, npc, ir, daddr;
    logic [XLEN-1:0] res, dwdata;
    logic [XLEN-1:0] rf [32];
    logic            ireq, dreq, dwe;

    logic [6:0]      op;
    logic [2:0]      f3;
    logic [4:0]      rd, rs1, rs2;
    logic            is_add, is_sub, is_addi, is_lw, is_sw, is_br, is_jal, is_ecall;
    logic            illegal, bad_reg, bad_addr, taken;
    logic [XLEN-1:0] a, b, imm, alu, ls_addr, target;

    assign imem.req   = ireq;
    assign imem.we    = 1'b0;
    assign imem.addr  = pc;
    assign imem.wdata = '0;
    assign dmem.req   = dreq;
    assign dmem.we    = dwe;
    assign dmem.addr  = daddr;
    assign dmem.wdata = dwdata;

    always_comb begin
        op       = ir[6:0];
        f3       = ir[14:12];
        rd       = ir[11:7];
        rs1      = ir[19:15];
        rs2      = ir[24:20];
        is_add   = op == 7'h33 && f3 == 3'b000 && ir[31:25] == 7'h00;
        is_sub   = op == 7'h33 && f3 == 3'b000 && ir[31:25] == 7'h20;
        is_addi  = op == 7'h13 && f3 == 3'b000;
        is_lw    = op == 7'h03 && f3 == 3'b010;
        is_sw    = op == 7'h23 && f3 == 3'b010;
        is_br    = op == 7'h63 && f3[2:1] == 2'b00;
        is_jal   = op == 7'h6f;
        is_ecall = ir == 32'h0000_0073;
        illegal  = !(is_add | is_sub | is_addi | is_lw | is_sw | is_br | is_jal | is_ecall);
        // only the register fields an instruction actually uses are range-checked
        bad_reg  = ((is_add | is_sub | is_addi | is_lw | is_sw | is_br) && {1'b0, rs1} >= NR)
                || ((is_add | is_sub | is_sw | is_br) && {1'b0, rs2} >= NR)
                || ((is_add | is_sub | is_addi | is_lw | is_jal) && {1'b0, rd} >= NR);
        a        = rf[rs1];
        b        = rf[rs2];
        imm      = is_sw  ? {{20{ir[31]}}, ir[31:25], ir[11:7]}
                 : is_br  ? {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0}
                 : is_jal ? {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0}
                 : {{20{ir[31]}}, ir[31:20]};
        alu      = is_sub ? a - b : a + (is_addi ? imm : b);
        ls_addr  = a + imm;
        target   = pc + imm;
        taken    = is_jal | (is_br & ((a == b) ^ f3[0]));
        bad_addr = (taken && target[1:0] != 2'b00) || ((is_lw | is_sw) && ls_addr[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= PC_RESET;
            npc     <= '0;
            ir      <= '0;
            res     <= '0;
            ireq    <= 1'b0;
            dreq    <= 1'b0;
            dwe     <= 1'b0;
            daddr   <= '0;
            dwdata  <= '0;
            halt    <= 1'b0;
            trap    <= 1'b0;
            retired <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (!ireq) ireq <= 1'b1;
                    else if (imem.ack) begin
                        ireq  <= 1'b0;
                        ir    <= imem.rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    npc <= is_jal ? target : pc + 32'd4;
                    if (illegal || bad_reg || bad_addr) begin
                        state <= HALT;
                        halt  <= 1'b1;
                        trap  <= 1'b1;
                    end else if (is_ecall) begin
                        state   <= HALT;
                        halt    <= 1'b1;
                        retired <= retired + 1'b1;
                    end else if (is_lw | is_sw) begin
                        dreq   <= 1'b1;
                        dwe    <= is_sw;
                        daddr  <= ls_addr;
                        dwdata <= b;
                        state  <= MEM;
                    end else if (is_br) begin
                        pc      <= taken ? target : pc + 32'd4;
                        retired <= retired + 1'b1;
                        ireq    <= 1'b1;
                        state   <= FETCH;
                    end else begin
                        res   <= is_jal ? pc + 32'd4 : alu;
                        state <= WB;
                    end
                end
                MEM: begin
                    if (dmem.ack) begin
                        dreq <= 1'b0;
                        if (dwe) begin
                            pc      <= npc;
                            retired <= retired + 1'b1;
                            ireq    <= 1'b1;
                            state   <= FETCH;
                        end else begin
                            res   <= dmem.rdata;
                            state <= WB;
                        end
                    end
                end
                WB: begin
                    if (rd != 5'd0) rf[rd] <= res;
                    pc      <= npc;
                    retired <= retired + 1'b1;
                    ireq    <= 1'b1;
                    state   <= FETCH;
                end
                default: ;
            endcase
        end
    end
endmodule
